event_queue: RTL and testbench
==============================

EVENT_QUEUE -- requirements
Module: event_queue

Interface
REQ-001 Parameters, one per line:
- BITS_PER_COORDINATE, 8, width of x and y.
- IN_CHANNELS, 4, spike-vector width.
- TS_BITS, 2, timestep tag width.
- DEPTH, 16, queue entries; power of two, >= 2.
- DROP_CNT_BITS, 16, drop counter width.
REQ-002 Ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  capture strobe; no backpressure.
- in_timestep  in  TS_BITS  event timestep tag.
- in_x  in  BITS_PER_COORDINATE  event x.
- in_y  in  BITS_PER_COORDINATE  event y.
- in_spikes  in  IN_CHANNELS  spike vector.
- ev_valid  out  1  head event presented to convolution.
- ev_timestep, ev_x, ev_y, ev_spikes  out  as inputs  presented event fields.
- conv_ready  in  1  convolution accepts presented event.
- conv_ack  in  1  convolution finished the accepted event.
- ts_done  out  1  one-cycle pulse: previous timestep fully processed.
- level  out  $clog2(DEPTH)+1  occupancy.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- drop_cnt  out  DROP_CNT_BITS  saturating count of lost events.

Function
REQ-003 Storage is a circular buffer of DEPTH entries {timestep, x, y, spikes} with wrapping read and write pointers.
REQ-004 Push on in_valid when not full, or when full and a pop occurs in the same cycle.
REQ-005 An in_valid event that is not pushed increments drop_cnt, which saturates at all-ones.
REQ-006 Simultaneous push and pop leaves level unchanged.
REQ-007 Pointers wrap from DEPTH-1 to 0.
REQ-008 The output FSM has four states: IDLE, PRESENT, WAIT_ACK, TS_SWITCH.
REQ-009 IDLE, queue not empty:
- head timestep == cur_ts -> PRESENT.
- head timestep != cur_ts -> TS_SWITCH.
REQ-010 TS_SWITCH lasts exactly one cycle: ts_done=1, cur_ts <= head timestep, then -> PRESENT.
REQ-011 PRESENT: ev_valid=1 and ev_* hold the head entry, stable until transfer.
REQ-012 Transfer = ev_valid && conv_ready; it pops the head, latches ev_* and moves to WAIT_ACK.
REQ-013 WAIT_ACK: ev_valid=0 and ev_* hold the transferred event; conv_ack -> IDLE.
REQ-014 conv_ack outside WAIT_ACK is ignored.
REQ-015 At most one event is outstanding, so every event of timestep t is acked before ts_done for t+1.
REQ-016 Latency: an event pushed into an empty queue with an idle FSM and matching timestep raises ev_valid on the 2nd rising edge after the push edge (push edge, then IDLE->PRESENT).
REQ-017 ts_done is asserted only in TS_SWITCH.
REQ-018 cur_ts comparison is equality only; TS_BITS wrap-around (max -> 0) counts as a timestep change.
REQ-019 full, empty and level are registered-state derived and reflect the current cycle's pointers.

Reset
REQ-020 While rst=1, asynchronously:
- pointers=0, level=0, empty=1, full=0.
- state=IDLE, cur_ts=0, drop_cnt=0.
- ev_valid=0, ev_*=0, ts_done=0.
REQ-021 Reset mid-operation discards queued and outstanding events.
REQ-022 The first post-reset event with timestep 0 produces no ts_done pulse.

Configuration
REQ-023 Macro EVENT_QUEUE_ZERO_FILTER_EN.
- Defined: in_valid events with in_spikes==0 are neither pushed nor counted in drop_cnt.
- Undefined: all-zero events are queued like any other.

Verification
REQ-024 Push 3 events ts=0, conv_ready=1, ack 2 cycles after each transfer -> presented in order, ev_valid 2 cycles after first push, no ts_done.
REQ-025 Push ts=0,0,1 -> ts_done pulses once for one cycle, only after the second ts=0 event's conv_ack, before ts=1 is presented.
REQ-026 DEPTH=4, conv_ready=0, 6 pushes -> full=1, level=4, drop_cnt=2; then drain -> first 4 events in order.
REQ-027 Full queue with push and transfer in the same cycle -> push accepted, level stays 4, drop_cnt unchanged.
REQ-028 Assert rst during WAIT_ACK with 3 queued -> ev_valid=0, level=0, cur_ts=0 immediately; later conv_ack is ignored.
REQ-029 in_spikes=0 push -> dropped silently with EVENT_QUEUE_ZERO_FILTER_EN defined; queued and presented without it.

Source files
------------

// File: rtl/event_queue.sv
// Event FIFO with one-outstanding-event handshake and timestep boundary pulse.
// Optional macro EVENT_QUEUE_ZERO_FILTER_EN discards all-zero spike vectors.
module event_queue #(
  parameter int unsigned BITS_PER_COORDINATE = 8,
  parameter int unsigned IN_CHANNELS         = 4,
  parameter int unsigned TS_BITS             = 2,
  parameter int unsigned DEPTH               = 16,
  parameter int unsigned DROP_CNT_BITS       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [TS_BITS-1:0]             in_timestep,
  input  logic [BITS_PER_COORDINATE-1:0] in_x,
  input  logic [BITS_PER_COORDINATE-1:0] in_y,
  input  logic [IN_CHANNELS-1:0]         in_spikes,
  output logic                           ev_valid,
  output logic [TS_BITS-1:0]             ev_timestep,
  output logic [BITS_PER_COORDINATE-1:0] ev_x,
  output logic [BITS_PER_COORDINATE-1:0] ev_y,
  output logic [IN_CHANNELS-1:0]         ev_spikes,
  input  logic                           conv_ready,
  input  logic                           conv_ack,
  output logic                           ts_done,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           full,
  output logic                           empty,
  output logic [DROP_CNT_BITS-1:0]       drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned W  = TS_BITS + 2*BITS_PER_COORDINATE + IN_CHANNELS;

  typedef enum logic [1:0] {
    IDLE, PRESENT, WAIT_ACK, TS_SWITCH
  } state_e;

  state_e                   state_q, state_d;
  logic [W-1:0]             mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [AW:0]              cnt_q;
  logic [TS_BITS-1:0]       cur_ts_q;
  logic [DROP_CNT_BITS-1:0] drop_q;
  logic [W-1:0]             ev_q;
  logic [W-1:0]             head;
  logic [W-1:0]             ev_bus;
  logic [TS_BITS-1:0]       head_ts;
  logic                     zero_ev, push, pop, drop;

`ifdef EVENT_QUEUE_ZERO_FILTER_EN
  assign zero_ev = (in_spikes == '0);
`else
  assign zero_ev = 1'b0;
`endif

  assign head    = mem_q[rd_ptr_q];
  assign head_ts = head[W-1 -: TS_BITS];
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign pop     = (state_q == PRESENT) && conv_ready;
  // A full queue still accepts when the head leaves in the same cycle
  assign push    = in_valid && !zero_ev && (!full || pop);
  assign drop    = in_valid && !zero_ev && !push;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_timestep, in_x, in_y, in_spikes};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      cur_ts_q <= '0;
      ev_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) cnt_q <= cnt_q + (AW+1)'(1);
      if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
      if (drop && !(&drop_q)) drop_q <= drop_q + DROP_CNT_BITS'(1);
      if (state_q == TS_SWITCH) cur_ts_q <= head_ts;
      if (pop) ev_q <= head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = (head_ts == cur_ts_q) ? PRESENT : TS_SWITCH;
      end
      TS_SWITCH: state_d = PRESENT;
      PRESENT:   if (conv_ready) state_d = WAIT_ACK;
      WAIT_ACK:  if (conv_ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_valid = (state_q == PRESENT);
    ts_done  = (state_q == TS_SWITCH);
    ev_bus   = ev_valid ? head : ev_q;
  end

  assign {ev_timestep, ev_x, ev_y, ev_spikes} = ev_bus;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_event_queue.sv
// Randomized and directed bench for event_queue against a queue-based model.
// Honours EVENT_QUEUE_ZERO_FILTER_EN when the design is built with it.
module tb_event_queue;

  localparam int D  = 4;
  localparam int DB = 4;
  localparam int W  = 22;

  logic       clk, rst;
  logic       in_valid;
  logic [1:0] in_timestep;
  logic [7:0] in_x, in_y;
  logic [3:0] in_spikes;
  logic       ev_valid;
  logic [1:0] ev_timestep;
  logic [7:0] ev_x, ev_y;
  logic [3:0] ev_spikes;
  logic       conv_ready, conv_ack, ts_done;
  logic [2:0] level;
  logic       full, empty;
  logic [3:0] drop_cnt;

  event_queue #(
    .BITS_PER_COORDINATE(8), .IN_CHANNELS(4), .TS_BITS(2),
    .DEPTH(D), .DROP_CNT_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_timestep(in_timestep), .in_x(in_x), .in_y(in_y),
    .in_spikes(in_spikes), .ev_valid(ev_valid),
    .ev_timestep(ev_timestep), .ev_x(ev_x), .ev_y(ev_y),
    .ev_spikes(ev_spikes), .conv_ready(conv_ready),
    .conv_ack(conv_ack), .ts_done(ts_done), .level(level),
    .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tsd_cnt = 0;

  // Model: 0 idle, 1 presenting, 2 awaiting ack, 3 timestep switch
  logic [W-1:0] mq[$];
  int           mph;
  logic [1:0]   mcur;
  int           mdrop;
  logic [W-1:0] mev;
  int           wt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] ts,
    input logic [7:0] x, input logic [7:0] y, input logic [3:0] sp);
    return {ts, x, y, sp};
  endfunction

  task automatic mreset();
    mq.delete();
    mph = 0; mcur = '0; mdrop = 0; mev = '0; wt = 0;
  endtask

  task automatic mstep();
    logic [W-1:0] hd;
    logic pop, push, zf, drp;
    int nph;
    hd = (mq.size() > 0) ? mq[0] : '0;
    pop = (mph == 1) && conv_ready;
    zf = 1'b0;
`ifdef EVENT_QUEUE_ZERO_FILTER_EN
    zf = in_valid && (in_spikes == 4'd0);
`endif
    push = in_valid && !zf && (mq.size() < D || pop);
    drp  = in_valid && !zf && !push;
    nph = mph;
    case (mph)
      0: if (mq.size() > 0) nph = (hd[W-1 -: 2] == mcur) ? 1 : 3;
      1: if (conv_ready) begin nph = 2; mev = hd; end
      2: if (conv_ack) nph = 0;
      default: begin mcur = hd[W-1 -: 2]; nph = 1; end
    endcase
    if (drp && mdrop < (1 << DB) - 1) mdrop++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({in_timestep, in_x, in_y, in_spikes});
    mph = nph;
  endtask

  task automatic cmp_all();
    logic [W-1:0] ee;
    ee = (mph == 1) ? mq[0] : mev;
    chk("ev_valid", ev_valid, mph == 1);
    chk("ts_done", ts_done, mph == 3);
    chk("ev_data", {ev_timestep, ev_x, ev_y, ev_spikes}, ee);
    chk("level", level, mq.size());
    chk("full", full, mq.size() == D);
    chk("empty", empty, mq.size() == 0);
    chk("drop_cnt", drop_cnt, mdrop);
    if (ts_done) tsd_cnt++;
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] e,
                     input logic rdy, input logic ack);
    in_valid = v;
    {in_timestep, in_x, in_y, in_spikes} = e;
    conv_ready = rdy;
    conv_ack = ack;
    @(posedge clk);
    mstep();
    #1;
    cmp_all();
  endtask

  task automatic serve(input int n);
    logic a;
    for (int i = 0; i < n; i++) begin
      a = 1'b0;
      if (mph == 2) begin a = (wt >= 1); wt++; end
      else wt = 0;
      cyc(1'b0, '0, 1'b1, a);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; conv_ready = 1'b0; conv_ack = 1'b0;
    #2 rst = 1'b1;
    #1 mreset();
    cmp_all();
    @(posedge clk);
    #1 rst = 1'b0;
    cmp_all();
    tsd_cnt = 0;
  endtask

  initial begin
    logic [1:0] rts;
    logic [3:0] sp;
    logic rdy, ack;
    int rp;
    rst = 1'b1;
    in_valid = 1'b0; in_timestep = '0; in_x = '0; in_y = '0;
    in_spikes = '0; conv_ready = 1'b0; conv_ack = 1'b0;
    mreset();
    #1 cmp_all();
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    cmp_all();

    // three ts=0 events: latency and ordering, no ts_done
    cyc(1'b1, mk(0, 8'h11, 8'h21, 4'h1), 1'b1, 1'b0);
    chk("lat_push_edge", ev_valid, 1'b0);
    cyc(1'b1, mk(0, 8'h12, 8'h22, 4'h2), 1'b1, 1'b0);
    chk("lat_next_edge", ev_valid, 1'b1);
    chk("lat_head_x", ev_x, 8'h11);
    cyc(1'b1, mk(0, 8'h13, 8'h23, 4'h3), 1'b1, 1'b0);
    serve(20);
    chk("no_tsdone_ts0", tsd_cnt, 0);

    // ts 0,0,1: one ts_done pulse
    do_reset();
    cyc(1'b1, mk(0, 8'h31, 8'h41, 4'h5), 1'b1, 1'b0);
    cyc(1'b1, mk(0, 8'h32, 8'h42, 4'h6), 1'b1, 1'b0);
    cyc(1'b1, mk(1, 8'h33, 8'h43, 4'h7), 1'b1, 1'b0);
    serve(30);
    chk("one_tsdone", tsd_cnt, 1);

    // overflow: 6 pushes into depth 4 without ready
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc(1'b1, mk(0, 8'(i), 8'(i + 100), 4'hf), 1'b0, 1'b0);
    chk("ovf_full", full, 1'b1);
    chk("ovf_level", level, 4);
    chk("ovf_drop", drop_cnt, 2);
    serve(30);
    chk("ovf_drained", level, 0);

    // full queue: push and transfer in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, mk(0, 8'(i), 8'h55, 4'h9), 1'b0, 1'b0);
    cyc(1'b1, mk(0, 8'h77, 8'h66, 4'ha), 1'b1, 1'b0);
    chk("fullpp_level", level, 4);
    chk("fullpp_drop", drop_cnt, 0);
    serve(30);

    // reset while awaiting ack with 3 queued
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, mk(1, 8'(i + 1), 8'h90, 4'h3), 1'b1, 1'b0);
    chk("pre_rst_level", level, 3);
    do_reset();
    chk("rst_evvalid", ev_valid, 1'b0);
    chk("rst_level", level, 0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, mk(0, 8'h5a, 8'ha5, 4'h4), 1'b1, 1'b0);
    serve(10);
    chk("post_rst_no_tsdone", tsd_cnt, 0);

    // all-zero spike vector
    do_reset();
    cyc(1'b1, mk(0, 8'h01, 8'h02, 4'h0), 1'b0, 1'b0);
`ifdef EVENT_QUEUE_ZERO_FILTER_EN
    chk("zero_level", level, 0);
`else
    chk("zero_level", level, 1);
`endif
    chk("zero_drop", drop_cnt, 0);
    serve(10);

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 25; i++)
      cyc(1'b1, mk(0, 8'(i), 8'h00, 4'h8), 1'b0, 1'b0);
    chk("drop_sat", drop_cnt, 15);
    serve(20);

    // randomized traffic
    do_reset();
    rts = '0;
    rp = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) rp = $urandom_range(1, 4);
      if ($urandom % 6 == 0) rts = rts + 2'd1;
      sp = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom);
      rdy = ($urandom % 4) < rp;
      ack = (mph == 2) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      cyc($urandom % 3 != 0, mk(rts, 8'($urandom), 8'($urandom), sp),
          rdy, ack);
      if ($urandom % 700 == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
